// File: rtl/seq_alu.sv
// seq_alu: handshaked sequential ALU with iterative shift-add multiply and optional restoring divide
// Build option: define SEQ_ALU_DIV_EN to enable the opcode 3 divider (default build has no divider logic).
// Ports: clk, rst (async, active-high); in_valid/in_ready offer A, B, ALU_Sel;
//   out_valid/out_ready release ALU_Out (low product/quotient), ALU_Hi (high product/remainder),
//   flags {Z,C,V,E}.
module seq_alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALU_Sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALU_Out,
  output logic [WIDTH-1:0] ALU_Hi,
  output logic [3:0]       flags
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [2*WIDTH-1:0] work, step, mul_nx;
  logic [WIDTH-1:0] opnd, s_out, s_hi;
  logic [WIDTH:0] msum, sum, dif;
  logic [3:0] s_flags;
  logic s_c, s_v, s_e, long_op, last, fin_z, accept;
  assign accept = state == IDLE && in_valid;
  assign last = cnt == CW'(WIDTH - 1);
  always_comb begin
    sum = {1'b0, A} + {1'b0, B};
    dif = {1'b0, A} - {1'b0, B};
    s_out = '0;
    s_hi = '0;
    s_c = 1'b0;
    s_v = 1'b0;
    s_e = 1'b0;
    case (ALU_Sel)
      4'd0: begin
        s_out = sum[WIDTH-1:0];
        s_c = sum[WIDTH];
        s_v = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      4'd1: begin
        s_out = dif[WIDTH-1:0];
        s_c = dif[WIDTH];
        s_v = (A[WIDTH-1] != B[WIDTH-1]) && (dif[WIDTH-1] != A[WIDTH-1]);
      end
`ifdef SEQ_ALU_DIV_EN
      4'd3: begin
        s_out = '1;
        s_hi = A;
        s_e = 1'b1;
      end
`else
      4'd3: s_e = 1'b1;
`endif
      4'd4: begin
        s_out = {A[WIDTH-2:0], 1'b0};
        s_c = A[WIDTH-1];
      end
      4'd5: begin
        s_out = {1'b0, A[WIDTH-1:1]};
        s_c = A[0];
      end
      4'd6: begin
        s_out = {A[WIDTH-2:0], A[WIDTH-1]};
        s_c = A[WIDTH-1];
      end
      4'd7: begin
        s_out = {A[0], A[WIDTH-1:1]};
        s_c = A[0];
      end
      4'd8: s_out = A & B;
      4'd9: s_out = A | B;
      4'd10: s_out = A ^ B;
      4'd11: s_out = ~(A | B);
      4'd12: s_out = ~(A & B);
      4'd13: s_out = ~(A ^ B);
      4'd14: s_out = WIDTH'(A > B);
      4'd15: s_out = WIDTH'(A == B);
      default: ;
    endcase
    s_flags = {s_out == '0, s_c, s_v, s_e};
  end
  // Multiply: work = {partial high, multiplier}; add multiplicand when the low bit is set, shift right.
  assign msum = {1'b0, work[2*WIDTH-1:WIDTH]} + (work[0] ? {1'b0, opnd} : '0);
  assign mul_nx = {msum, work[WIDTH-1:1]};
`ifdef SEQ_ALU_DIV_EN
  // Divide: work = {remainder, dividend/quotient}; shift one dividend bit in, keep the trial subtract if non-negative.
  logic op_div;
  logic [WIDTH:0] shifted, trial;
  assign shifted = {work[2*WIDTH-1:WIDTH], work[WIDTH-1]};
  assign trial = shifted - {1'b0, opnd};
  assign step = !op_div ? mul_nx :
                trial[WIDTH] ? {shifted[WIDTH-1:0], work[WIDTH-2:0], 1'b0} :
                {trial[WIDTH-1:0], work[WIDTH-2:0], 1'b1};
  assign fin_z = op_div ? step[WIDTH-1:0] == '0 : step == '0;
  assign long_op = ALU_Sel == 4'd2 || (ALU_Sel == 4'd3 && B != '0);
  always_ff @(posedge clk or posedge rst)
    if (rst) op_div <= 1'b0;
    else if (accept) op_div <= ALU_Sel == 4'd3;
`else
  assign step = mul_nx;
  assign fin_z = step == '0;
  assign long_op = ALU_Sel == 4'd2;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (in_valid) state_nx = long_op ? BUSY : DONE;
      BUSY: if (last) state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    in_ready = state == IDLE;
    out_valid = state == DONE;
  end
  // The final iteration and the result latch share the last BUSY edge.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      work <= '0;
      opnd <= '0;
      ALU_Out <= '0;
      ALU_Hi <= '0;
      flags <= '0;
    end else if (accept) begin
      cnt <= '0;
      opnd <= ALU_Sel == 4'd2 ? A : B;
      work <= {{WIDTH{1'b0}}, ALU_Sel == 4'd2 ? B : A};
      if (!long_op) begin
        ALU_Out <= s_out;
        ALU_Hi <= s_hi;
        flags <= s_flags;
      end
    end else if (state == BUSY) begin
      cnt <= cnt + CW'(1);
      work <= step;
      if (last) begin
        ALU_Out <= step[WIDTH-1:0];
        ALU_Hi <= step[2*WIDTH-1:WIDTH];
        flags <= {fin_z, 3'b000};
      end
    end
endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width (legal 4..32).
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  operation offered.
REQ-005 SHALL have port in_ready  output  1  block can accept an operation.
REQ-006 SHALL have port A  input  WIDTH  operand A.
REQ-007 SHALL have port B  input  WIDTH  operand B.
REQ-008 SHALL have port ALU_Sel  input  4  opcode.
REQ-009 SHALL have port out_valid  output  1  result held on outputs.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port ALU_Out  output  WIDTH  primary result (low product, quotient).
REQ-012 SHALL have port ALU_Hi  output  WIDTH  high product / remainder, else 0.
REQ-013 SHALL have port flags  output  4  {Z,C,V,E}: zero, carry/borrow, signed overflow, error.

Function
REQ-014 SHALL use opcodes: 0 add, 1 sub, 2 mul (unsigned), 3 div (unsigned), 4 shl 1, 5 shr 1, 6 rotl 1, 7 rotr 1, 8 and, 9 or, 10 xor, 11 nor, 12 nand, 13 xnor, 14 A>B ? 1 : 0, 15 A==B ? 1 : 0.
REQ-015 SHALL implement FSM states IDLE, BUSY, DONE; in_ready=1 only in IDLE.
REQ-016 SHALL capture A, B, ALU_Sel on the clk edge where in_valid && in_ready.
REQ-017 Single-cycle ops (all except 2, 3) SHALL go IDLE->DONE; out_valid asserts the cycle after acceptance.
REQ-018 Mul SHALL be iterative shift-add: IDLE->BUSY, WIDTH cycles in BUSY, then DONE; out_valid asserts WIDTH+1 cycles after acceptance.
REQ-019 Div SHALL be iterative restoring: same timing as mul; ALU_Out=quotient, ALU_Hi=remainder.
REQ-020 DONE SHALL hold ALU_Out, ALU_Hi, flags stable until out_valid && out_ready, then go to IDLE; no new operation is accepted in the same cycle.
REQ-021 Add/sub SHALL compute WIDTH+1 bits; C = bit WIDTH (borrow for sub); V = two's-complement overflow; other ops C=V=0 except shl/rotl C=A[WIDTH-1], shr/rotr C=A[0].
REQ-022 Z SHALL be 1 iff ALU_Out==0 (mul: full 2*WIDTH product==0).
REQ-023 Div with B==0 SHALL finish in one cycle (IDLE->DONE) with ALU_Out all ones, ALU_Hi=A, E=1.
REQ-024 Inputs changing during BUSY/DONE SHALL have no effect; in_valid ignored while in_ready=0.
REQ-025 out_ready held high in DONE SHALL release the result after exactly one out_valid cycle.

Reset
REQ-026 Asserting rst at any time, including mid-BUSY, SHALL immediately force IDLE, in_ready=1, out_valid=0, ALU_Out=0, ALU_Hi=0, flags=0, and discard the operation in progress.
REQ-027 First acceptance SHALL be possible on the first clk edge after rst deasserts.

Configuration
REQ-028 Macro SEQ_ALU_DIV_EN defined: opcode 3 SHALL behave per REQ-019/REQ-023.
REQ-029 Macro SEQ_ALU_DIV_EN undefined: no divider logic; opcode 3 SHALL complete single-cycle with ALU_Out=0, ALU_Hi=0, flags={1,0,0,1}.

Verification
REQ-030 WIDTH=8, A=10, B=2, sweep ALU_Sel 1..5, out_ready=1 -> ALU_Out 8, 20 (Hi 0), 5 (Hi 0), 20, 5; latencies 1, 8+1, 8+1, 1, 1.
REQ-031 A=8'hFF, B=8'h01, add -> ALU_Out 8'h00, flags Z=1 C=1 V=0; A=8'h7F, B=8'h01 add -> 8'h80, V=1.
REQ-032 A=200, B=0, div (macro defined) -> one-cycle, ALU_Out 8'hFF, ALU_Hi 200, E=1; macro undefined, opcode 3 -> ALU_Out 0, flags 4'b1001.
REQ-033 A=15, B=15, mul, out_ready=0 for 5 cycles after out_valid -> ALU_Out 8'hE1, ALU_Hi 8'h00, held stable, in_ready=0 until the handshake.
REQ-034 Mul accepted, rst pulsed at BUSY cycle 4 -> outputs zero next cycle, in_ready=1; new add 3+4 -> ALU_Out 7 one cycle later.
